dma_mem_master: RTL and testbench

//  Bus initiator for the shared single-port word memory (WR / Data / addr port).

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_xfer_ctr.sv | 55 +++++
 rtl/dma_mem_master.sv | 137 +++++++++++++
 tb/tb_dma_mem_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA memory master and its transfer counter.
package dma_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 192;
  localparam int RD_LAT    = 1;

  typedef logic [DATA_W-1:0] dma_word_t;
  typedef logic [ADDR_W-1:0] dma_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_xfer_ctr.sv
// Source/destination pointers, remaining-word count and written-word count of one transfer.
module dma_xfer_ctr
  import dma_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      step,
  input  dma_addr_t src_addr,
  input  dma_addr_t dst_addr,
  input  dma_addr_t len,
  output dma_addr_t src_ptr,
  output dma_addr_t dst_ptr,
  output dma_addr_t words,
  output logic      last
);

  localparam dma_addr_t ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  dma_addr_t src_ptr_r;
  dma_addr_t dst_ptr_r;
  dma_addr_t rem_r;
  dma_addr_t words_r;

  // Pointer and count registers: load at accept, advance once per written word.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr_r <= {ADDR_W{1'b0}};
      dst_ptr_r <= {ADDR_W{1'b0}};
      rem_r     <= {ADDR_W{1'b0}};
      words_r   <= {ADDR_W{1'b0}};
    end else if (load) begin
      src_ptr_r <= src_addr;
      dst_ptr_r <= dst_addr;
      rem_r     <= len;
      words_r   <= {ADDR_W{1'b0}};
    end else if (step) begin
      src_ptr_r <= src_ptr_r + ONE;
      dst_ptr_r <= dst_ptr_r + ONE;
      rem_r     <= rem_r - ONE;
      words_r   <= words_r + ONE;
    end else begin
      src_ptr_r <= src_ptr_r;
      dst_ptr_r <= dst_ptr_r;
      rem_r     <= rem_r;
      words_r   <= words_r;
    end
  end

  assign src_ptr = src_ptr_r;
  assign dst_ptr = dst_ptr_r;
  assign words   = words_r;
  assign last    = (rem_r == ONE);

endmodule

// File: rtl/dma_mem_master.sv
// DMA transfer engine: copies len words from src to dst over a shared single-port memory bus.
module dma_mem_master
  import dma_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  dma_addr_t src_addr,
  input  dma_addr_t dst_addr,
  input  dma_addr_t len,
  output logic      busy,
  output logic      done,
  output logic      err,
  output dma_addr_t words,
  output logic      mem_wr,
  output dma_addr_t mem_addr,
  inout  dma_word_t mem_data
);

  localparam int               CNT_W   = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RD_LAT);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam dma_addr_t        ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  dma_state_t       state_r, next_s;
  logic [CNT_W-1:0] rd_cnt_r;
  dma_word_t        data_q_r;
  logic             busy_r, done_r, err_r, mem_wr_r;
  dma_addr_t        mem_addr_r;

  logic             load_s, step_s, cap_s, err_s, last_s, range_bad_s;
  dma_addr_t        addr_s, src_ptr_s, dst_ptr_s;
  logic [ADDR_W:0]  src_end_s, dst_end_s;

  dma_xfer_ctr u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .src_ptr  (src_ptr_s),
    .dst_ptr  (dst_ptr_s),
    .words    (words),
    .last     (last_s)
  );

  // The carry bit keeps the end address exact so ranges can never wrap.
  assign src_end_s   = {1'b0, src_addr} + {1'b0, len};
  assign dst_end_s   = {1'b0, dst_addr} + {1'b0, len};
  assign range_bad_s = (src_end_s > DEPTH_L) || (dst_end_s > DEPTH_L);

  // Next state plus the bus address for the coming cycle, so bus outputs stay registered.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    cap_s  = 1'b0;
    err_s  = 1'b0;
    addr_s = {ADDR_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == {ADDR_W{1'b0}}) begin
            next_s = DONE;
          end else if (range_bad_s) begin
            next_s = DONE;
            err_s  = 1'b1;
          end else begin
            next_s = RD;
            load_s = 1'b1;
            addr_s = src_addr;
          end
        end else begin
          next_s = IDLE;
        end
      end
      RD: begin
        if (rd_cnt_r == CNT_END) begin
          next_s = WR;
          cap_s  = 1'b1;
          addr_s = dst_ptr_s;
        end else begin
          next_s = RD;
          addr_s = src_ptr_s;
        end
      end
      WR: begin
        step_s = 1'b1;
        if (last_s) begin
          next_s = DONE;
        end else begin
          next_s = RD;
          addr_s = src_ptr_s + ONE;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, read-latency counter, captured data word and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rd_cnt_r   <= {CNT_W{1'b0}};
      data_q_r   <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      mem_wr_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= next_s;
      rd_cnt_r   <= ((state_r == RD) && (next_s == RD)) ? rd_cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
      data_q_r   <= cap_s ? mem_data : data_q_r;
      busy_r     <= (next_s == RD) || (next_s == WR);
      done_r     <= (next_s == DONE);
      err_r      <= err_s;
      mem_wr_r   <= (next_s == WR);
      mem_addr_r <= addr_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign mem_wr   = mem_wr_r;
  assign mem_addr = mem_addr_r;
  assign mem_data = mem_wr_r ? data_q_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_dma_mem_master.sv
// Directed bench for dma_mem_master with a behavioural 192-word memory (1-cycle read latency).
module tb_dma_mem_master;
  import dma_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      start = 1'b0;
  dma_addr_t src_addr = 8'd0;
  dma_addr_t dst_addr = 8'd0;
  dma_addr_t len = 8'd0;
  logic      busy, done, err, mem_wr;
  dma_addr_t words, mem_addr;
  tri1 [31:0] mem_data;

  dma_word_t mem [0:191];
  dma_word_t rd_q = 32'd0;
  logic      tb_oe = 1'b0;
  logic      pl_en = 1'b0;
  dma_addr_t pl_addr = 8'd0;
  dma_word_t pl_data = 32'd0;
  int        wr_cnt = 0;
  int        n_cmp = 0;
  int        n_bad = 0;

  dma_mem_master dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .words    (words),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory drives Data only when enabled by the bench and the master is reading.
  assign mem_data = (!mem_wr && tb_oe) ? rd_q : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      if (mem_addr < 8'd192) mem[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
    rd_q <= (mem_addr < 8'd192) ? mem[mem_addr] : 32'hdead_beef;
  end

  task automatic poke(input dma_addr_t a, input dma_word_t d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic accept(input dma_addr_t s, input dma_addr_t d, input dma_addr_t n);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tb_oe = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, mem_wr} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b need 0000", {busy, done, err, mem_wr});
    end
    n_cmp++;
    if (words !== 8'd0 || mem_addr !== 8'd0) begin
      n_bad++; $display("FAIL reset_regs words=%0d addr=%0d need 0/0", words, mem_addr);
    end
    n_cmp++;
    if (mem_data !== 32'hffff_ffff) begin
      n_bad++; $display("FAIL reset_bus_released got %h need ffffffff", mem_data);
    end
  endtask

  task automatic test_copy;
    int done_cyc;
    int exp_addr;
    int widx;
    dma_word_t vals [0:2];
    vals[0] = 32'd8; vals[1] = 32'd9; vals[2] = 32'd12;
    for (int i = 0; i < 3; i++) poke(8'(1 + i), vals[i]);
    for (int i = 0; i < 3; i++) poke(8'(100 + i), 32'd0);
    tb_oe = 1'b1;
    done_cyc = 0;
    accept(8'd1, 8'd100, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_cyc == 0) done_cyc = k;
      widx = k / 3 - 1;
      exp_addr = (k >= 10) ? 0 : ((k % 3 == 0) ? 100 + widx : 1 + (k - 1) / 3);
      n_cmp++;
      if (mem_wr !== (k % 3 == 0 && k <= 9) || mem_addr !== 8'(exp_addr)) begin
        n_bad++; $display("FAIL copy_trace cyc %0d wr=%b addr=%0d need addr %0d", k, mem_wr, mem_addr, exp_addr);
      end
      n_cmp++;
      if (busy !== (k <= 9)) begin
        n_bad++; $display("FAIL copy_busy cyc %0d got %b", k, busy);
      end
      n_cmp++;
      if (mem_wr === 1'b1) begin
        if (mem_data !== vals[widx]) begin
          n_bad++; $display("FAIL bus_write cyc %0d got %h need %h", k, mem_data, vals[widx]);
        end
      end else if (mem_data !== rd_q) begin
        n_bad++; $display("FAIL bus_single_driver cyc %0d got %h need %h", k, mem_data, rd_q);
      end
      if (k == 10) begin
        n_cmp++;
        if (err !== 1'b0 || words !== 8'd3) begin
          n_bad++; $display("FAIL copy_status err=%b words=%0d need 0/3", err, words);
        end
      end
    end
    n_cmp++;
    if (done_cyc != 10) begin
      n_bad++; $display("FAIL copy_done_cycle got %0d need 10", done_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[100 + i] !== vals[i]) begin
        n_bad++; $display("FAIL copy_dst[%0d] got %0d need %0d", 100 + i, mem[100 + i], vals[i]);
      end
    end
    tb_oe = 1'b0;
  endtask

  task automatic test_noop;
    int w0;
    w0 = wr_cnt;
    accept(8'd1, 8'd100, 8'd0);
    @(negedge clk);
    n_cmp++;
    if ({done, err, busy, mem_wr} !== 4'b1000 || mem_data !== 32'hffff_ffff) begin
      n_bad++; $display("FAIL noop_done got d/e/b/w=%b data=%h need 1000/ffffffff", {done, err, busy, mem_wr}, mem_data);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || wr_cnt != w0 || mem[100] !== 32'd8) begin
      n_bad++; $display("FAIL noop_quiet done=%b writes=%0d mem100=%0d need 0/0/8", done, wr_cnt - w0, mem[100]);
    end
  endtask

  task automatic test_range;
    dma_addr_t srcs [0:1];
    dma_addr_t dsts [0:1];
    int w0;
    srcs[0] = 8'd190; dsts[0] = 8'd0;
    srcs[1] = 8'd0;   dsts[1] = 8'd190;
    for (int t = 0; t < 2; t++) begin
      w0 = wr_cnt;
      accept(srcs[t], dsts[t], 8'd3);
      @(negedge clk);
      n_cmp++;
      if ({done, err, busy, mem_wr} !== 4'b1100) begin
        n_bad++; $display("FAIL range_err[%0d] got d/e/b/w=%b need 1100", t, {done, err, busy, mem_wr});
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (wr_cnt != w0 || err !== 1'b0) begin
        n_bad++; $display("FAIL range_nowrite[%0d] writes=%0d err=%b need 0/0", t, wr_cnt - w0, err);
      end
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    int done_cyc;
    for (int i = 0; i < 4; i++) poke(8'(10 + i), 32'h11 + 32'(i));
    tb_oe = 1'b1;
    w0 = wr_cnt;
    done_cyc = 0;
    accept(8'd10, 8'd20, 8'd4);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_cyc == 0) done_cyc = k;
      start = (k == 1);
      src_addr = 8'd50; dst_addr = 8'd60; len = 8'd2;
    end
    start = 1'b0;
    n_cmp++;
    if (wr_cnt - w0 != 4 || done_cyc != 13) begin
      n_bad++; $display("FAIL b2b_count writes=%0d done_cyc=%0d need 4/13", wr_cnt - w0, done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[20 + i] !== 32'h11 + 32'(i)) begin
        n_bad++; $display("FAIL b2b_dst[%0d] got %h need %h", 20 + i, mem[20 + i], 32'h11 + 32'(i));
      end
    end
    tb_oe = 1'b0;
  endtask

  task automatic test_abort;
    int w0;
    int seen_done;
    for (int i = 0; i < 5; i++) poke(8'(30 + i), 32'h21 + 32'(i));
    for (int i = 0; i < 5; i++) poke(8'(40 + i), 32'd0);
    tb_oe = 1'b1;
    accept(8'd30, 8'd40, 8'd5);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (mem_wr !== 1'b1 || mem_addr !== 8'd41) begin
      n_bad++; $display("FAIL abort_setup wr=%b addr=%0d need 1/41", mem_wr, mem_addr);
    end
    rst = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({mem_wr, busy, done} !== 3'b000 || mem_data !== 32'hffff_ffff) begin
      n_bad++; $display("FAIL abort_release w/b/d=%b data=%h need 000/ffffffff", {mem_wr, busy, done}, mem_data);
    end
    w0 = wr_cnt;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    n_cmp++;
    if (seen_done != 0 || wr_cnt != w0) begin
      n_bad++; $display("FAIL abort_quiet done_seen=%0d writes=%0d need 0/0", seen_done, wr_cnt - w0);
    end
    n_cmp++;
    if (mem[40] !== 32'h21 || mem[41] !== 32'h22 || mem[42] !== 32'd0) begin
      n_bad++; $display("FAIL abort_dst got %h %h %h need 21 22 0", mem[40], mem[41], mem[42]);
    end
  endtask

  initial begin
    for (int i = 0; i < 192; i++) mem[i] = 32'd0;
    test_reset;
    test_copy;
    test_noop;
    test_range;
    test_back_to_back;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
